// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the 16x-oversampled receiver.
package uart_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int UART_TICKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        UART_TX_IDLE   = 3'd0,
        UART_TX_START  = 3'd1,
        UART_TX_DATA   = 3'd2,
        UART_TX_STOP   = 3'd3,
        UART_TX_PARITY = 3'd4
    } uart_tx_state_e;

    // Even parity when odd=0; inverted for odd parity.
    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO with sync active-low reset; DEPTH must be a power of 2 (>= 2).
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A write while full is dropped; simultaneous push/pop leaves the count alone.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, fed by a small write FIFO and paced by a 16x baud enable.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT
`ifdef UART_TX_PARITY_EN
    ,
    parameter logic PARITY_ODD  = 1'b0
`endif
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      tx_clk_en,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_wr,
    output logic                      tx_full,
    output logic                      tx_empty,
    output logic                      tx_busy,
    output logic                      tx,
    output logic [2:0]                tx_state_dbg
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BW = $clog2(UART_DATA_BITS);

    uart_tx_state_e            state_q;
    logic [TW-1:0]             tick_q;
    logic [BW-1:0]             bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      tx_q;
    logic                      busy_q;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q;
`endif

    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      fifo_pop;
    logic                      tick_end;

    assign tick_end = (tick_q == TW'(TICKS_PER_BIT - 1));

    // The FSM pops on the same enable edge that drives the start bit, either from
    // IDLE or straight out of the last stop tick for gapless back-to-back frames.
    assign fifo_pop = tx_clk_en && !fifo_empty &&
                      ((state_q == UART_TX_IDLE) || ((state_q == UART_TX_STOP) && tick_end));

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .push_i  (tx_wr),
        .pop_i   (fifo_pop),
        .wdata_i (tx_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= UART_TX_IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (tx_clk_en) begin
            tick_q <= tick_end ? '0 : tick_q + TW'(1);
            case (state_q)
                UART_TX_IDLE: begin
                    tick_q <= '0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (fifo_pop) begin
                        shift_q <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
                        parity_q <= uart_parity(fifo_rdata, PARITY_ODD);
`endif
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= UART_TX_START;
                    end
                end
                UART_TX_START: begin
                    if (tick_end) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= UART_TX_DATA;
                    end
                end
                UART_TX_DATA: begin
                    if (tick_end) begin
                        if (bit_idx_q != BW'(UART_DATA_BITS - 1)) begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + BW'(1);
                        end else begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= UART_TX_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= UART_TX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                UART_TX_PARITY: begin
                    if (tick_end) begin
                        tx_q    <= 1'b1;
                        state_q <= UART_TX_STOP;
                    end
                end
`endif
                UART_TX_STOP: begin
                    if (tick_end) begin
                        if (fifo_pop) begin
                            shift_q <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
                            parity_q <= uart_parity(fifo_rdata, PARITY_ODD);
`endif
                            tx_q    <= 1'b0;
                            state_q <= UART_TX_START;
                        end else begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= UART_TX_IDLE;
                        end
                    end
                end
                default: begin
                    tick_q  <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= UART_TX_IDLE;
                end
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_full      = fifo_full;
    assign tx_empty     = fifo_empty;
    assign tx_state_dbg = state_q;

endmodule
